// File: rtl/screensaver_pkg.sv
// Shared VGA 640x480@60 timing constants, colour type and image-select codes.
package screensaver_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IMG_CHECKER = 2'd0,
    IMG_FRACTAL = 2'd1
  } image_sel_t;

  localparam rgb_t RGB_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t RGB_WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t RGB_BLUE  = '{r: 4'h0, g: 4'h0, b: 4'h8};

endpackage

// File: rtl/screensaver_top_vga_timing.sv
// VGA raster counters, visible flag, unregistered active-low syncs and frame count.
// Frame animation is enabled by defining SCREENSAVER_ANIMATE_EN.
module vga_timing
  import screensaver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       visible,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] frame
);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hc;
  logic [9:0] vc;
  logic       frame_end;

  assign frame_end = (hc == H_LAST) && (vc == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

`ifdef SCREENSAVER_ANIMATE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            frame <= '0;
    else if (frame_end) frame <= frame + 8'd1;
  end
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
  assign frame = '0;
`endif

  assign x       = hc;
  assign y       = vc[8:0];
  assign visible = (hc < H_VIS) && (vc < V_VIS);
  assign hsync   = !((hc >= H_SYNC_BEG) && (hc < H_SYNC_END));
  assign vsync   = !((vc >= V_SYNC_BEG) && (vc < V_SYNC_END));

endmodule

// File: rtl/screensaver_top.sv
// VGA screensaver: checkerboard or Sierpinski image, registered sync and colour.
// Animation (frame counting) is enabled by defining SCREENSAVER_ANIMATE_EN.
module screensaver_top
  import screensaver_pkg::*;
#(
  parameter int IMAGE_SELECT = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  logic [9:0] x;
  logic [8:0] y;
  logic       visible;
  logic       hs;
  logic       vs;
  logic [7:0] frame;
  logic [9:0] xs;
  rgb_t       pix;

  vga_timing u_timing (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .y       (y),
    .visible (visible),
    .hsync   (hs),
    .vsync   (vs),
    .frame   (frame)
  );

  // 10-bit wrapping scroll offset; bit 5 selects the 32-pixel square column
  assign xs = x + {2'b00, frame};

  always_comb begin
    pix = RGB_BLACK;
    if (visible) begin
      if (IMAGE_SELECT == int'(IMG_CHECKER)) begin
        pix = (xs[5] ^ y[5]) ? RGB_BLUE : RGB_WHITE;
      end else if (IMAGE_SELECT == int'(IMG_FRACTAL)) begin
        if ((x[8:0] & y) == '0) pix = '{r: 4'hF, g: y[8:5], b: frame[3:0]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else begin
      hsync <= hs;
      vsync <= vs;
      r     <= pix.r;
      g     <= pix.g;
      b     <= pix.b;
    end
  end

endmodule

// File: tb/tb_screensaver_top.sv
// Directed bench for screensaver_top: three instances (checkerboard, fractal, black).
// Raster position is jumped by briefly forcing the timing counters to keep runtime short.
module tb_screensaver_top;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  logic       hs0, vs0, hs1, vs1, hs2, vs2;
  logic [3:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;

  screensaver_top #(.IMAGE_SELECT(0)) dut0 (.clk(clk), .rst(rst), .hsync(hs0), .vsync(vs0), .r(r0), .g(g0), .b(b0));
  screensaver_top #(.IMAGE_SELECT(1)) dut1 (.clk(clk), .rst(rst), .hsync(hs1), .vsync(vs1), .r(r1), .g(g1), .b(b1));
  screensaver_top #(.IMAGE_SELECT(2)) dut2 (.clk(clk), .rst(rst), .hsync(hs2), .vsync(vs2), .r(r2), .g(g2), .b(b2));

  int passed = 0;
  int total  = 0;

  logic [9:0] jh, jv;

  typedef struct {
    int         img;
    int         x;
    int         y;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[19];

`ifdef SCREENSAVER_ANIMATE_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  function automatic logic [11:0] rgb_of(input int img);
    case (img)
      0:       return {r0, g0, b0};
      1:       return {r1, g1, b1};
      default: return {r2, g2, b2};
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Place all three rasters at (jh,jv); the next rising edge registers that pixel.
  task jump(input int h, input int v);
    @(negedge clk);
    jh = 10'(h);
    jv = 10'(v);
    force dut0.u_timing.hc = jh;
    force dut0.u_timing.vc = jv;
    force dut1.u_timing.hc = jh;
    force dut1.u_timing.vc = jv;
    force dut2.u_timing.hc = jh;
    force dut2.u_timing.vc = jv;
    #1;
    release dut0.u_timing.hc;
    release dut0.u_timing.vc;
    release dut1.u_timing.hc;
    release dut1.u_timing.vc;
    release dut2.u_timing.hc;
    release dut2.u_timing.vc;
  endtask

  initial begin
    int first_fall, first_rise, second_fall, blank_err, xerr, cnt, hfalls;
    logic prev;

    vecs = '{
      '{0,   0,   0, 12'hFFF}, '{0,  32,   0, 12'h008}, '{0,  32,  32, 12'hFFF},
      '{0,   0,  32, 12'h008}, '{0, 639, 479, 12'h008}, '{0, 640,   0, 12'h000},
      '{0, 100, 480, 12'h000}, '{0, 799, 100, 12'h000},
      '{1,   1,   2, 12'hF00}, '{1,   3,   1, 12'h000}, '{1,   0, 479, 12'hFE0},
      '{1, 256, 256, 12'h000}, '{1, 512,   0, 12'hF00}, '{1, 100, 160, 12'h000},
      '{1,  64, 128, 12'hF40}, '{1, 640,   2, 12'h000}, '{1,   5, 481, 12'h000},
      '{2,   0,   0, 12'h000}, '{2,  32,   0, 12'h000}
    };

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("reset_hsync", int'(hs1), 1);
    check("reset_vsync", int'(vs1), 1);
    check("reset_rgb0",  int'(rgb_of(0)), 0);
    check("reset_rgb1",  int'(rgb_of(1)), 0);

    // Horizontal timing from reset release; edge k shows counter state hc=k-1
    @(negedge clk);
    rst = 1'b0;
    first_fall = -1; first_rise = -1; second_fall = -1; blank_err = 0;
    prev = 1'b1;
    for (int k = 1; k <= 1500; k++) begin
      tick();
      if (((k - 1) % 800) >= 640 && (rgb_of(0) != 0 || rgb_of(1) != 0)) blank_err++;
      if (prev && !hs1) begin
        if (first_fall < 0) first_fall = k;
        else if (second_fall < 0) second_fall = k;
      end
      if (!prev && hs1 && first_rise < 0) first_rise = k;
      prev = hs1;
    end
    check("hsync_first_low", first_fall, 657);
    check("hsync_low_width", first_rise - first_fall, 96);
    check("hsync_period", second_fall - first_fall, 800);
    check("hblank_rgb_zero", blank_err, 0);
    check("hsync_same_all", int'({hs0, hs2}), int'({hs1, hs1}));

    // Pixel table, frame 0
    for (int i = 0; i < 19; i++) begin
      jump(vecs[i].x, vecs[i].y);
      tick();
      check($sformatf("pix_img%0d_(%0d,%0d)", vecs[i].img, vecs[i].x, vecs[i].y),
            int'(rgb_of(vecs[i].img)), int'(vecs[i].exp));
    end

    // Vertical sync: counters reach (0,490) 10 edges after (790,489), output one edge later
    jump(790, 489);
    cnt = 0;
    while (vs1 && cnt < 100) begin tick(); cnt++; end
    check("vsync_fall_latency", cnt, 11);
    cnt = 0; hfalls = 0; xerr = 0; prev = hs1;
    while (!vs1 && cnt < 3000) begin
      tick(); cnt++;
      if (prev && !hs1) hfalls++;
      prev = hs1;
      if ($isunknown({hs0, vs0, r0, g0, b0, hs1, vs1, r1, g1, b1, hs2, vs2, r2, g2, b2})) xerr++;
    end
    check("vsync_low_width", cnt, 1600);
    check("hsync_during_vsync", hfalls, 2);
    check("no_x_outputs", xerr, 0);

    // Animation: each end-of-frame jump lets the real frame counter step
    repeat (7) begin jump(799, 524); tick(); end
    jump(25, 0); tick();
    check("anim_checker_f7", int'(rgb_of(0)), ANIM ? 12'h008 : 12'hFFF);
    jump(0, 0); tick();
    check("anim_fractal_f7", int'(rgb_of(1)), ANIM ? 12'hF07 : 12'hF00);
    repeat (249) begin jump(799, 524); tick(); end
    jump(25, 0); tick();
    check("frame_wrap_checker", int'(rgb_of(0)), 12'hFFF);
    jump(0, 0); tick();
    check("frame_wrap_fractal", int'(rgb_of(1)), 12'hF00);

    // Mid-frame reset clears frame and restarts raster immediately
    repeat (3) begin jump(799, 524); tick(); end
    jump(300, 200); tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset_rgb", int'(rgb_of(1)), 0);
    check("async_reset_sync", int'({hs1, vs1}), 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_reset_pix00", int'(rgb_of(1)), 12'hF00);
    cnt = 1;
    while (hs1 && cnt < 2000) begin tick(); cnt++; end
    check("post_reset_hsync_low", cnt, 657);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
